// File: rtl/cu_pkg.sv
// Shared state encoding and opcode/field helpers for seq_control_unit.
package cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  localparam int unsigned OP_NOP = 0;

  function automatic int unsigned op_halt(input int unsigned op_w);
    return (32'd1 << op_w) - 32'd1;
  endfunction

  function automatic int unsigned op_brz(input int unsigned op_w);
    return op_halt(op_w) - 32'd1;
  endfunction

  // Low bit of register field idx (0 = A, 1 = B, 2 = W) above the opcode.
  function automatic int unsigned field_lo(input int unsigned op_w,
                                           input int unsigned ra_w,
                                           input int unsigned idx);
    return op_w + idx * ra_w;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: splits IR into fields and classifies the opcode.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int WORD_W = 20,
  parameter int OP_W   = 5,
  parameter int RA_W   = 5
) (
  input  logic [WORD_W-1:0] i_ir,
  output logic [OP_W-1:0]   o_opcode,
  output logic [RA_W-1:0]   o_ra_a,
  output logic [RA_W-1:0]   o_ra_b,
  output logic [RA_W-1:0]   o_ra_w,
  output logic              o_is_nop,
  output logic              o_is_brz,
  output logic              o_is_halt,
  output logic              o_is_alu
);

  localparam int unsigned A_LO = field_lo(OP_W, RA_W, 0);
  localparam int unsigned B_LO = field_lo(OP_W, RA_W, 1);
  localparam int unsigned W_LO = field_lo(OP_W, RA_W, 2);
  localparam int          USED = OP_W + 3 * RA_W;

  assign o_opcode  = i_ir[OP_W-1:0];
  assign o_ra_a    = i_ir[A_LO +: RA_W];
  assign o_ra_b    = i_ir[B_LO +: RA_W];
  assign o_ra_w    = i_ir[W_LO +: RA_W];

  assign o_is_nop  = (o_opcode == OP_W'(OP_NOP));
  assign o_is_brz  = (o_opcode == OP_W'(op_brz(OP_W)));
  assign o_is_halt = (o_opcode == OP_W'(op_halt(OP_W)));
  assign o_is_alu  = !(o_is_nop || o_is_brz || o_is_halt);

  // Instruction bits above the W field carry no meaning.
  generate
    if (USED < WORD_W) begin : g_spare
      logic w_unused_hi;
      assign w_unused_hi = ^i_ir[WORD_W-1:USED];
    end
  endgenerate

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle fetch/decode/execute/write-back sequencer with memory and ALU handshakes.
// Optional breakpoint support is enabled by defining CU_BREAKPOINT_EN.
module seq_control_unit
  import cu_pkg::*;
#(
  parameter  int WORD_W     = 20,
  parameter  int REG_CNT    = 32,
  parameter  int IMEM_DEPTH = 32,
  parameter  int OP_W       = 5,
  localparam int RA_W       = $clog2(REG_CNT),
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [RA_W-1:0]   rf_addr_a,
  output logic [RA_W-1:0]   rf_addr_b,
  input  logic [WORD_W-1:0] rf_rdata_a,
  input  logic [WORD_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [WORD_W-1:0] alu_result,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
`ifdef CU_BREAKPOINT_EN
  ,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_en,
  output logic              bp_hit
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic                r_entry;
  logic [PC_W-1:0]     r_pc;
  logic [WORD_W-1:0]   r_ir;
  logic [WORD_W-1:0]   r_opa;
  logic [WORD_W-1:0]   r_opb;
  logic [WORD_W-1:0]   r_result;
  logic                w_bp_trip;

  logic [OP_W-1:0]     w_opcode;
  logic [RA_W-1:0]     w_ra_a;
  logic [RA_W-1:0]     w_ra_b;
  logic [RA_W-1:0]     w_ra_w;
  logic                w_is_nop;
  logic                w_is_brz;
  logic                w_is_halt;
  logic                w_is_alu;

`ifdef CU_BREAKPOINT_EN
  logic                r_bp_hit;
  logic                r_bp_skip;
`endif

  cu_decoder #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W),
    .RA_W   (RA_W)
  ) u_decoder (
    .i_ir      (r_ir),
    .o_opcode  (w_opcode),
    .o_ra_a    (w_ra_a),
    .o_ra_b    (w_ra_b),
    .o_ra_w    (w_ra_w),
    .o_is_nop  (w_is_nop),
    .o_is_brz  (w_is_brz),
    .o_is_halt (w_is_halt),
    .o_is_alu  (w_is_alu)
  );

  always_comb begin
    w_next    = r_state;
    w_bp_trip = 1'b0;
`ifdef CU_BREAKPOINT_EN
    // Breakpoint is evaluated only on the first FETCH cycle, before any request.
    w_bp_trip = (r_state == S_FETCH) && r_entry && bp_en &&
                (r_pc == bp_addr) && !r_bp_skip;
`endif
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (w_bp_trip)     w_next = S_HALTED;
        else if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_halt)     w_next = S_HALTED;
        else if (w_is_alu) w_next = S_EXEC;
        else               w_next = S_FETCH;
      end
      S_EXEC:   if (alu_done) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALTED: if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_entry  <= 1'b0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      case (r_state)
        S_IDLE:  if (start) r_pc <= '0;
        S_FETCH: if (!w_bp_trip && imem_ack) r_ir <= imem_rdata;
        S_DECODE: begin
          r_opa <= rf_rdata_a;
          r_opb <= rf_rdata_b;
          if (w_is_nop)
            r_pc <= r_pc + PC_W'(1);
          else if (w_is_brz)
            r_pc <= (rf_rdata_a == '0) ? rf_rdata_b[PC_W-1:0] : r_pc + PC_W'(1);
        end
        S_EXEC:  if (alu_done) r_result <= alu_result;
        S_WB:    r_pc <= r_pc + PC_W'(1);
        S_HALTED: begin
`ifdef CU_BREAKPOINT_EN
          if (start && !r_bp_hit) r_pc <= '0;
`else
          if (start) r_pc <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef CU_BREAKPOINT_EN
  // A resume from a breakpoint halt skips the check for exactly one fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp_hit  <= 1'b0;
      r_bp_skip <= 1'b0;
    end else if (r_state == S_HALTED && start) begin
      r_bp_hit  <= 1'b0;
      r_bp_skip <= r_bp_hit;
    end else begin
      if (w_bp_trip) r_bp_hit <= 1'b1;
      if (r_state == S_FETCH && w_next != S_FETCH) r_bp_skip <= 1'b0;
    end
  end

  assign bp_hit = r_bp_hit;
`endif

  assign imem_req  = (r_state == S_FETCH) && !w_bp_trip;
  assign imem_addr = r_pc;
  assign rf_addr_a = w_ra_a;
  assign rf_addr_b = w_ra_b;
  assign rf_we     = (r_state == S_WB);
  assign rf_waddr  = w_ra_w;
  assign rf_wdata  = r_result;
  assign alu_start = (r_state == S_EXEC) && r_entry;
  assign alu_op    = w_opcode;
  assign alu_a     = r_opa;
  assign alu_b     = r_opb;
  assign pc        = r_pc;
  assign busy      = !(r_state == S_IDLE || r_state == S_HALTED);
  assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_seq_control_unit;

  localparam int WORD_W = 20;
  localparam int REG_CNT = 32;
  localparam int IMEM_DEPTH = 32;
  localparam int OP_W = 5;
  localparam int RA_W = 5;
  localparam int PC_W = 5;

  logic clk = 1'b0;
  logic rst, start;
  logic imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic [RA_W-1:0] rf_addr_a, rf_addr_b, rf_waddr;
  logic [WORD_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic rf_we, alu_start, alu_done, busy, halted;
  logic [OP_W-1:0] alu_op;
  logic [WORD_W-1:0] alu_a, alu_b, alu_result;
  logic [PC_W-1:0] pc;
`ifdef CU_BREAKPOINT_EN
  logic [PC_W-1:0] bp_addr;
  logic bp_en, bp_hit;
`endif

  always #5 clk = ~clk;

  seq_control_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef CU_BREAKPOINT_EN
    , .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit)
`endif
  );

  // Environment: instruction memory, register file and a latency-programmable ALU.
  logic [WORD_W-1:0] imem [IMEM_DEPTH];
  logic [WORD_W-1:0] rf [REG_CNT];
  logic [WORD_W-1:0] rf_init [REG_CNT];
  int L, M;
  logic force_iack, force_adone;
  int icnt, dcnt;
  logic apend;
  int we_cnt, as_cnt;
  int fetch_q[$];
  logic prev_req, prev_exec;
  logic [PC_W-1:0] prev_addr;
  logic [OP_W+2*WORD_W-1:0] prev_ops;
  int addr_viol = 0;
  int op_viol = 0;
  int total = 0;
  int bad = 0;

  function automatic logic [WORD_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                 input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
    return a + (b ^ {b[9:0], b[19:10]}) + {15'd0, op};
  endfunction

  function automatic logic [WORD_W-1:0] ins(input logic [4:0] op, input logic [4:0] a,
                                              input logic [4:0] b, input logic [4:0] w);
    return {w, b, a, op};
  endfunction

  assign imem_ack   = (imem_req && (icnt >= L)) || force_iack;
  assign imem_rdata = imem[imem_addr];
  assign rf_rdata_a = rf[rf_addr_a];
  assign rf_rdata_b = rf[rf_addr_b];
  assign alu_done   = ((alu_start || apend) && (dcnt >= M)) || force_adone;
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (rst) begin
      rf <= rf_init;
      we_cnt <= 0;
      as_cnt <= 0;
      icnt <= 0;
      dcnt <= 0;
      apend <= 1'b0;
      fetch_q.delete();
      prev_req <= 1'b0;
      prev_exec <= 1'b0;
    end else begin
      if (rf_we) begin
        rf[rf_waddr] <= rf_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (alu_start) as_cnt <= as_cnt + 1;
      if (imem_req && imem_ack) fetch_q.push_back(int'(imem_addr));
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= ((alu_start || apend) && !alu_done) ? dcnt + 1 : 0;
      if (alu_done) apend <= 1'b0;
      else if (alu_start) apend <= 1'b1;
      prev_req <= imem_req && !imem_ack;
      prev_exec <= (alu_start || apend) && !alu_done;
    end
    prev_addr <= imem_addr;
    prev_ops <= {alu_op, alu_a, alu_b};
  end

  always @(negedge clk) begin
    if (!rst && prev_req && imem_req && imem_addr != prev_addr) addr_viol++;
    if (!rst && prev_exec && apend && {alu_op, alu_a, alu_b} != prev_ops) op_viol++;
  end

  logic outs_any;
`ifdef CU_BREAKPOINT_EN
  assign outs_any = |{imem_req, imem_addr, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
                      alu_start, alu_op, alu_a, alu_b, pc, busy, halted, bp_hit};
`else
  assign outs_any = |{imem_req, imem_addr, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
                      alu_start, alu_op, alu_a, alu_b, pc, busy, halted};
`endif

  // Instruction-level reference model results.
  logic [WORD_W-1:0] exp_rf [REG_CNT];
  int exp_pcs[$];
  int exp_cyc, exp_nw, exp_pc;
  bit exp_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_run();
    logic [WORD_W-1:0] r [REG_CNT];
    logic [WORD_W-1:0] word;
    int p, a, b, w;
    r = rf_init;
    p = 0;
    exp_cyc = 0;
    exp_nw = 0;
    exp_ok = 0;
    exp_pcs.delete();
    for (int s = 0; s < 100; s++) begin
      word = imem[p];
      a = int'(word[9:5]);
      b = int'(word[14:10]);
      w = int'(word[19:15]);
      exp_pcs.push_back(p);
      if (word[4:0] == 5'd31) begin
        exp_cyc += 2 + L;
        exp_ok = 1;
        break;
      end else if (word[4:0] == 5'd0) begin
        p = (p + 1) % IMEM_DEPTH;
        exp_cyc += 2 + L;
      end else if (word[4:0] == 5'd30) begin
        p = (r[a] == '0) ? int'(r[b][4:0]) : (p + 1) % IMEM_DEPTH;
        exp_cyc += 2 + L;
      end else begin
        r[w] = alu_fn(word[4:0], r[a], r[b]);
        exp_nw++;
        p = (p + 1) % IMEM_DEPTH;
        exp_cyc += 4 + L + M;
      end
    end
    exp_rf = r;
    exp_pc = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, input bit poke, output int n);
    n = 0;
    while (!halted && n < budget) begin
      if (poke && n == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
  endtask

  task automatic check_run(input string tag, input int n);
    int sz;
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_writes"}, 32'(we_cnt), 32'(exp_nw));
    chk({tag, "_alu_starts"}, 32'(as_cnt), 32'(exp_nw));
    chk({tag, "_fetch_len"}, 32'(fetch_q.size()), 32'(exp_pcs.size()));
    sz = (fetch_q.size() < exp_pcs.size()) ? fetch_q.size() : exp_pcs.size();
    for (int i = 0; i < sz; i++)
      chk($sformatf("%s_fetch%0d", tag, i), 32'(fetch_q[i]), 32'(exp_pcs[i]));
    for (int i = 0; i < REG_CNT; i++)
      chk($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(exp_rf[i]));
    chk({tag, "_addr_stable"}, 32'(addr_viol), 32'd0);
    chk({tag, "_ops_stable"}, 32'(op_viol), 32'd0);
  endtask

  task automatic gen_prog();
    int k;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2)       imem[i] = ins(5'd0, 5'($urandom), 5'($urandom), 5'($urandom));
      else if (k < 4)  imem[i] = ins(5'd30, 5'($urandom), 5'($urandom), 5'($urandom));
      else if (k == 4) imem[i] = ins(5'd31, 5'd0, 5'd0, 5'd0);
      else imem[i] = ins(5'($urandom_range(1, 29)), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    for (int i = 0; i < REG_CNT; i++)
      rf_init[i] = ($urandom_range(0, 3) == 0) ? '0 : WORD_W'($urandom);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = ins(5'd31, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < REG_CNT; i++) rf_init[i] = WORD_W'(32'h100 + i);
  endtask

  initial begin
    int n;
    logic [WORD_W-1:0] v5;
    rst = 1'b1;
    start = 1'b0;
    force_iack = 1'b0;
    force_adone = 1'b0;
    L = 0;
    M = 0;
`ifdef CU_BREAKPOINT_EN
    bp_en = 1'b0;
    bp_addr = '0;
`endif
    fill_halt();
    do_reset();

    // Reset state
    chk("reset_outputs", {31'd0, outs_any}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);

    // ALU instruction, zero-wait
    fill_halt();
    imem[0] = ins(5'd3, 5'd1, 5'd2, 5'd5);
    do_reset();
    start_run();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alu_we_c%0d", k), {31'd0, rf_we}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("alu_start_c%0d", k), {31'd0, alu_start}, (k == 2) ? 32'd1 : 32'd0);
      if (k < 3) @(negedge clk);
    end
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", 32'(rf_wdata), 32'(alu_fn(5'd3, rf_init[1], rf_init[2])));
    @(negedge clk);
    chk("alu_pc_after", 32'(pc), 32'd1);
    chk("alu_we_after", {31'd0, rf_we}, 32'd0);

    // BRZ taken and not taken
    for (int t = 0; t < 2; t++) begin
      fill_halt();
      for (int i = 0; i < 4; i++) imem[i] = ins(5'd0, 5'd0, 5'd0, 5'd0);
      imem[4] = ins(5'd30, 5'd1, 5'd2, 5'd7);
      rf_init[1] = (t == 0) ? 20'h0 : 20'h1;
      rf_init[2] = 20'h00017;
      model_run();
      do_reset();
      start_run();
      run_to_halt(exp_cyc + 20, 1'b1, n);
      check_run(t == 0 ? "brz_taken" : "brz_not", n);
      chk(t == 0 ? "brz_taken_target" : "brz_not_target",
          (fetch_q.size() > 5) ? 32'(fetch_q[5]) : 32'hFFFF_FFFF, (t == 0) ? 32'h17 : 32'd5);
    end

    // Memory and ALU stalls
    fill_halt();
    imem[0] = ins(5'd7, 5'd3, 5'd4, 5'd9);
    L = 3;
    M = 2;
    model_run();
    do_reset();
    start_run();
    run_to_halt(exp_cyc + 20, 1'b1, n);
    check_run("stall", n);
    chk("stall_cycles_abs", 32'(n), 32'd14);

    // HALT at 31, restart from 0
    L = 0;
    M = 0;
    fill_halt();
    for (int i = 0; i < 31; i++) imem[i] = ins(5'd0, 5'd0, 5'd0, 5'd0);
    model_run();
    do_reset();
    start_run();
    run_to_halt(exp_cyc + 20, 1'b0, n);
    check_run("halt31", n);
    imem[0] = ins(5'd31, 5'd0, 5'd0, 5'd0);
    start_run();
    run_to_halt(20, 1'b0, n);
    chk("restart_halted", {31'd0, halted}, 32'd1);
    chk("restart_fetch0", (fetch_q.size() > 0) ? 32'(fetch_q[$]) : 32'hFFFF_FFFF, 32'd0);
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_cycles", 32'(n), 32'd2);

    // NOP at 31 wraps to 0
    fill_halt();
    rf_init[0] = 20'h0;
    rf_init[1] = 20'h0001F;
    imem[0] = ins(5'd30, 5'd0, 5'd1, 5'd0);
    imem[31] = ins(5'd0, 5'd0, 5'd0, 5'd0);
    do_reset();
    start_run();
    repeat (2) @(negedge clk);
    chk("wrap_fetch31", 32'(imem_addr), 32'd31);
    repeat (2) @(negedge clk);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_fetch0", 32'(imem_addr), 32'd0);

    // Reset during EXEC, then late handshakes
    fill_halt();
    imem[0] = ins(5'd3, 5'd1, 5'd2, 5'd5);
    M = 20;
    do_reset();
    start_run();
    repeat (2) @(negedge clk);
    chk("rstx_alu_start", {31'd0, alu_start}, 32'd1);
    @(negedge clk);
    chk("rstx_stall_start", {31'd0, alu_start}, 32'd0);
    chk("rstx_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_adone = 1'b1;
    force_iack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstx_outs%0d", k), {31'd0, outs_any}, 32'd0);
      @(negedge clk);
    end
    force_adone = 1'b0;
    force_iack = 1'b0;
    chk("rstx_no_we", 32'(we_cnt), 32'd0);
    chk("rstx_idle", {30'd0, busy, halted}, 32'd0);
    M = 0;

`ifdef CU_BREAKPOINT_EN
    // Breakpoint at address 2, then resume
    fill_halt();
    imem[0] = ins(5'd3, 5'd1, 5'd2, 5'd5);
    imem[1] = ins(5'd0, 5'd0, 5'd0, 5'd0);
    imem[2] = ins(5'd4, 5'd5, 5'd5, 5'd6);
    bp_en = 1'b1;
    bp_addr = 5'd2;
    do_reset();
    start_run();
    run_to_halt(40, 1'b0, n);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    chk("bp_hit", {31'd0, bp_hit}, 32'd1);
    chk("bp_pc", 32'(pc), 32'd2);
    chk("bp_fetches", 32'(fetch_q.size()), 32'd2);
    chk("bp_cycles", 32'(n), 32'd7);
    start_run();
    chk("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
    chk("bp_resume_addr", 32'(imem_addr), 32'd2);
    run_to_halt(40, 1'b0, n);
    chk("bp_resume_fetch", (fetch_q.size() > 2) ? 32'(fetch_q[2]) : 32'hFFFF_FFFF, 32'd2);
    chk("bp_final_pc", 32'(pc), 32'd3);
    v5 = alu_fn(5'd3, rf_init[1], rf_init[2]);
    chk("bp_r6", 32'(rf[6]), 32'(alu_fn(5'd4, v5, v5)));
    bp_en = 1'b0;
`endif

    // Random programs against the reference model
    for (int t = 0; t < 6; t++) begin
      L = $urandom_range(0, 2);
      M = $urandom_range(0, 2);
      exp_ok = 0;
      for (int tries = 0; tries < 50 && !exp_ok; tries++) begin
        gen_prog();
        model_run();
      end
      if (!exp_ok) begin
        imem[0] = ins(5'd31, 5'd0, 5'd0, 5'd0);
        model_run();
      end
      do_reset();
      start_run();
      run_to_halt(exp_cyc + 20, 1'b1, n);
      check_run($sformatf("rnd%0d", t), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
